ctrl_encoder: RTL and testbench

CTRL_ENCODER -- requirements
Module: ctrl_encoder

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/ctrl_fifo2.sv | 52 +++++
 rtl/ctrl_encoder.sv | 61 ++++++
 tb/tb_ctrl_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Opcode and ALU-class constants shared by the MIPS control encoder and decoder,
// plus the control-word classification function.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ILLEGAL = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam int ENC_W = 7;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic       illegal;
  } enc_t;

  // sw and beq leave regdst/memtoreg as don't-cares.
  function automatic enc_t encode(input ctrl_t c);
    enc_t e;
    e.illegal = 1'b0;
    if (c.regdst && !c.alusrc && !c.memtoreg && c.regwrite && !c.memwrite &&
        !c.branch && c.aluop == ALU_FUNCT)
      e.opcode = OP_RTYPE;
    else if (!c.regdst && c.alusrc && c.memtoreg && c.regwrite && !c.memwrite &&
             !c.branch && c.aluop == ALU_ADD)
      e.opcode = OP_LW;
    else if (c.alusrc && !c.regwrite && c.memwrite && !c.branch && c.aluop == ALU_ADD)
      e.opcode = OP_SW;
    else if (!c.alusrc && !c.regwrite && !c.memwrite && c.branch && c.aluop == ALU_SUB)
      e.opcode = OP_BEQ;
    else begin
      e.opcode  = OP_ILLEGAL;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/ctrl_fifo2.sv
// Two-entry valid/ready FIFO; one-cycle latency into an empty buffer, in_ready is
// purely occupancy-based (a same-cycle pop does not reopen a full buffer).
module ctrl_fifo2
  import mips_ctrl_pkg::*;
#(
  parameter int W = ENC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = rst_n && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/ctrl_encoder.sv
// Encodes MIPS control words into primary opcodes, buffered two deep; latency 1,
// in_ready drops while two words are held. Illegal words are flagged and counted.
module ctrl_encoder
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       memtoreg,
  input  logic       memwrite,
  input  logic       branch,
  input  logic       ALUsrc,
  input  logic       regdst,
  input  logic       regwrite,
  input  logic [1:0] ALUop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] opcode,
  output logic       out_illegal,
  output logic [7:0] illegal_cnt
);

  ctrl_t ctrl;
  enc_t  enc_in;
  enc_t  enc_out;
  logic  accept;

  assign ctrl = '{regdst:   regdst,
                  alusrc:   ALUsrc,
                  memtoreg: memtoreg,
                  regwrite: regwrite,
                  memwrite: memwrite,
                  branch:   branch,
                  aluop:    ALUop};

  assign enc_in = encode(ctrl);
  assign accept = in_valid && in_ready;

  ctrl_fifo2 #(.W(ENC_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (enc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (enc_out)
  );

  assign opcode      = enc_out.opcode;
  assign out_illegal = enc_out.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= 8'd0;
    else if (accept && enc_in.illegal && illegal_cnt != 8'hFF)
      illegal_cnt <= illegal_cnt + 8'd1;
  end

endmodule

// File: tb/tb_ctrl_encoder.sv
// Scoreboard bench for ctrl_encoder: stimulus pushes expected words, a negedge
// monitor pops and compares each delivered word.
module tb_ctrl_encoder;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       memtoreg, memwrite, branch, ALUsrc, regdst, regwrite;
  logic [1:0] ALUop;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] opcode;
  logic       out_illegal;
  logic [7:0] illegal_cnt;

  // Control word packing: {regdst, ALUsrc, memtoreg, regwrite, memwrite, branch, ALUop}
  localparam logic [7:0] W_RTYPE = 8'b1001_0010;
  localparam logic [7:0] W_LW    = 8'b0111_0000;
  localparam logic [7:0] W_SW    = 8'b0100_1000;
  localparam logic [7:0] W_SW_DC = 8'b1110_1000;
  localparam logic [7:0] W_BEQ   = 8'b0000_0101;
  localparam logic [7:0] W_BAD   = 8'b0000_1100;
  localparam logic [7:0] W_BAD2  = 8'b1111_1111;

  typedef struct {
    logic [5:0] op;
    logic       ill;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;

  ctrl_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .memtoreg    (memtoreg),
    .memwrite    (memwrite),
    .branch      (branch),
    .ALUsrc      (ALUsrc),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .ALUop       (ALUop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode      (opcode),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got opcode %b, expected nothing", opcode);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_opcode", 32'(opcode), 32'(e.op));
        check("pop_illegal", 32'(out_illegal), 32'(e.ill));
        if (e.lat)
          check("pop_latency", 32'(cyc - e.acc), 32'd1);
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic [5:0] op, input logic ill);
    bit done = 1'b0;
    {regdst, ALUsrc, memtoreg, regwrite, memwrite, branch, ALUop} = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.op  = op;
        e.ill = ill;
        e.acc = cyc;
        e.lat = lat_mode;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %b not accepted, required acceptance", w);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (sb.size() == 0 && !out_valid) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words pending, required 0", sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    {regdst, ALUsrc, memtoreg, regwrite, memwrite, branch, ALUop} = 8'h00;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Four legal words back-to-back, latency checked by the monitor.
    out_ready = 1'b1;
    lat_mode = 1'b1;
    send(W_RTYPE, 6'b000000, 1'b0);
    check("first_lat_valid", 32'(out_valid), 32'd1);
    send(W_LW,    6'b100011, 1'b0);
    send(W_SW,    6'b101011, 1'b0);
    send(W_BEQ,   6'b000100, 1'b0);
    lat_mode = 1'b0;
    drain();

    // sw with don't-cares set, then an illegal branch+memwrite word.
    send(W_SW_DC, 6'b101011, 1'b0);
    send(W_BAD,   6'b111111, 1'b1);
    drain();
    check("cnt_after_one_illegal", 32'(illegal_cnt), 32'd1);

    // Backpressure: two accepted, third held off while head is stable.
    out_ready = 1'b0;
    send(W_RTYPE, 6'b000000, 1'b0);
    send(W_LW,    6'b100011, 1'b0);
    {regdst, ALUsrc, memtoreg, regwrite, memwrite, branch, ALUop} = W_BEQ;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_head_stable", 32'(opcode), 32'(OP_RTYPE));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(W_BEQ, 6'b000100, 1'b0);
    drain();

    // Simultaneous push and pop at occupancy 1.
    out_ready = 1'b0;
    send(W_SW, 6'b101011, 1'b0);
    out_ready = 1'b1;
    send(W_BEQ, 6'b000100, 1'b0);
    check("pp_out_valid", 32'(out_valid), 32'd1);
    check("pp_head_new", 32'(opcode), 32'(OP_BEQ));
    check("pp_in_ready", 32'(in_ready), 32'd1);
    drain();
    @(negedge clk);
    check("pp_no_dup", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset mid-traffic with two words buffered.
    out_ready = 1'b0;
    send(W_BAD, 6'b111111, 1'b1);
    send(W_LW,  6'b100011, 1'b0);
    check("pre_rst_cnt", 32'(illegal_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_partial", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // 300 illegal words: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      send((i % 2 == 0) ? W_BAD : W_BAD2, 6'b111111, 1'b1);
      if (i == 253) check("cnt_254", 32'(illegal_cnt), 32'd254);
    end
    drain();
    check("cnt_saturated", 32'(illegal_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
